mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle RV32 core.
- Accepts one request at a time and registers it before forwarding it to memory. Routes the single response back to the owner.
- Round-robin arbitration when both units request in the same cycle.
- A response timeout returns an error to the owner so a hung memory cannot stall the core forever.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Mask width is DATA_W/8.
- TIMEOUT, 255, maximum WAIT cycles before an error response. 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  fetch request.
- ifu_req_ready  out  1  fetch request accepted this cycle.
- ifu_req_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  fetch response, one-cycle pulse.
- ifu_rsp_data  out  DATA_W  fetched instruction word.
- ifu_rsp_err  out  1  fetch timed out or memory error.
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  load/store request accepted.
- lsu_req_addr  in  ADDR_W  load/store address.
- lsu_req_wen  in  1  1 = store, 0 = load.
- lsu_req_wdata  in  DATA_W  store data.
- lsu_req_wmask  in  DATA_W/8  byte enables.
- lsu_rsp_valid  out  1  load/store response pulse.
- lsu_rsp_data  out  DATA_W  load data; 0 for stores.
- lsu_rsp_err  out  1  error flag.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  registered address.
- mem_req_wen  out  1  registered write enable.
- mem_req_wdata  out  DATA_W  registered write data.
- mem_req_wmask  out  DATA_W/8  registered mask; 4'b1111 for IFU requests.
- mem_rsp_valid  in  1  memory response.
- mem_rsp_data  in  DATA_W  read data.
- mem_rsp_err  in  1  memory error.
- busy  out  1  state is not IDLE.

Behaviour:
- States and owner:
  - FSM states are IDLE, ISSUE and WAIT.
  - The owner register holds IFU or LSU.
  - last_grant holds the last served unit.
- Reset (asynchronous, any state):
  - State goes to IDLE, last_grant to LSU, and all latched request registers and the timeout counter to 0.
  - Every output is 0.
- IDLE:
  - Arbitration is combinational on the current valids.
  - Only one valid: that unit wins.
  - Both valid: the unit that is not last_grant wins. After reset the IFU wins the first conflict.
  - The winner's req_ready is 1 this cycle. The loser's ready stays 0, and it must hold its valid.
  - Addr, wen, wdata and wmask are latched. An IFU request latches wen=0, wdata=0, wmask all-ones.
  - The owner is set to the winner and the state moves to ISSUE.
  - req_ready is never 1 outside IDLE.
- ISSUE:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready the state moves to WAIT and the counter is cleared.
  - ISSUE never times out.
- WAIT:
  - mem_req_valid=0.
  - On mem_rsp_valid:
    - Owner rsp_valid=1 for exactly that cycle.
    - rsp_data=mem_rsp_data, or 0 if owner=LSU with a store.
    - rsp_err=mem_rsp_err.
    - last_grant is set to the owner and the state moves to IDLE.
  - Otherwise the counter increments. When TIMEOUT≠0 and counter==TIMEOUT-1 with no response:
    - Owner rsp_valid=1, rsp_err=1, rsp_data=0.
    - last_grant is set to the owner and the state moves to IDLE.
- Latency: accept at T, mem request at T+1. With an immediate mem_req_ready and a response at T+2, rsp_valid is at T+2. The next accept is at T+3.
- A response in the same cycle as the counter hitting the limit wins: normal response, no error.
- mem_rsp_valid in IDLE or ISSUE is a stray response (includes late responses after a timeout or reset). It is ignored and produces no rsp pulse to either unit.
- The non-owner's rsp_valid is always 0. rsp_data and rsp_err are 0 when rsp_valid=0.
- The counter is wide enough to reach TIMEOUT and saturates; it never wraps.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - the owner enum (OWN_IFU, OWN_LSU);
  - the MASK_ALL constant;
  - the counter-width function.
- One sub-module, rr_arb2: a two-requester round-robin picker. Inputs are two valids and last_grant; outputs are a one-hot grant. It is purely combinational.
- The FSM, request latches and timeout counter stay in mem_arbiter.

Test Plan:
- IFU-only load: ifu addr 0x80000000; memory ready at once, data 0x00000413 two cycles later. Expect mem_req_addr 0x80000000, mask 4'hF, ifu_rsp_valid one cycle with data 0x00000413, lsu_rsp_valid=0 throughout.
- Simultaneous requests after reset: IFU 0x80000004 and LSU store 0x80001000/0xDEADBEEF/mask 4'h3. Expect IFU served first, then the LSU with mem_req_wen=1, wmask 4'h3. lsu_rsp_data=0. A second simultaneous pair is served in IFU-then-LSU order again, because last_grant alternates.
- Backpressure: hold mem_req_ready=0 for 5 cycles in ISSUE. Expect mem_req_* stable, both req_ready=0, and no timeout.
- Timeout with TIMEOUT=4: no mem_rsp_valid. Expect lsu_rsp_valid with err=1, data=0 on the 4th WAIT cycle. A late mem_rsp_valid in IDLE produces no response pulse.
- Response on the timeout cycle: mem_rsp_valid=1 with data 0x12345678 at counter==TIMEOUT-1. Expect err=0, data 0x12345678.
- Reset asserted mid-WAIT: outputs go to 0 immediately and the state returns to IDLE. A subsequent stray mem_rsp_valid is ignored. The first conflict after reset grants the IFU.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IFU/LSU data-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam int unsigned MAX_MASK_W = 64;
   localparam logic [MAX_MASK_W-1:0] MASK_ALL = '1;

   // Width able to hold the value `limit` itself; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Request/response bundle between the IFU, LSU, data memory and the arbiter.
interface mem_arb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned MASK_W = DATA_W / 8;

   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_req_addr;
   logic              ifu_rsp_valid;
   logic [DATA_W-1:0] ifu_rsp_data;
   logic              ifu_rsp_err;

   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic [ADDR_W-1:0] lsu_req_addr;
   logic              lsu_req_wen;
   logic [DATA_W-1:0] lsu_req_wdata;
   logic [MASK_W-1:0] lsu_req_wmask;
   logic              lsu_rsp_valid;
   logic [DATA_W-1:0] lsu_rsp_data;
   logic              lsu_rsp_err;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_wen;
   logic [DATA_W-1:0] mem_req_wdata;
   logic [MASK_W-1:0] mem_req_wmask;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_data;
   logic              mem_rsp_err;

   // Arbiter side.
   modport slave (
      input  ifu_req_valid, ifu_req_addr,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
      input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
   );

   // Units plus memory side.
   modport master (
      output ifu_req_valid, ifu_req_addr,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
      output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err
   );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; grant_o[0] = IFU, grant_o[1] = LSU.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       req_ifu_i,
   input  logic       req_lsu_i,
   input  owner_e     last_grant_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      if (req_ifu_i && req_lsu_i) begin
         grant_o = (last_grant_i == OWN_LSU) ? 2'b01 : 2'b10;
      end else if (req_ifu_i) begin
         grant_o = 2'b01;
      end else if (req_lsu_i) begin
         grant_o = 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between IFU and LSU: one registered request in
// flight, round-robin on conflict, response timeout returns an error.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic     clk,
   input  logic     reset,
   mem_arb_if.slave bus,
   output logic     busy
);

   localparam int unsigned MW = DATA_W / 8;
   localparam int unsigned CW = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MW-1:0]     wmask_q, wmask_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [1:0]        grant;
   logic              ifu_ready, lsu_ready, mem_valid;
   logic              rsp_v, rsp_err;
   logic [DATA_W-1:0] rsp_data;

   // Reset gates the requests so ready stays low while reset is held.
   rr_arb2 u_rr (
      .req_ifu_i   (bus.ifu_req_valid & ~reset),
      .req_lsu_i   (bus.lsu_req_valid & ~reset),
      .last_grant_i(last_q),
      .grant_o     (grant)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      addr_d    = addr_q;
      wen_d     = wen_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      cnt_d     = cnt_q;
      ifu_ready = 1'b0;
      lsu_ready = 1'b0;
      mem_valid = 1'b0;
      rsp_v     = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = '0;
      unique case (state_q)
         IDLE: begin
            if (grant[0]) begin
               ifu_ready = 1'b1;
               owner_d   = OWN_IFU;
               addr_d    = bus.ifu_req_addr;
               wen_d     = 1'b0;
               wdata_d   = '0;
               wmask_d   = MASK_ALL[MW-1:0];
               state_d   = ISSUE;
            end else if (grant[1]) begin
               lsu_ready = 1'b1;
               owner_d   = OWN_LSU;
               addr_d    = bus.lsu_req_addr;
               wen_d     = bus.lsu_req_wen;
               wdata_d   = bus.lsu_req_wdata;
               wmask_d   = bus.lsu_req_wmask;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            mem_valid = 1'b1;
            if (bus.mem_req_ready) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            // A response arriving on the limit cycle takes priority over the timeout.
            if (bus.mem_rsp_valid) begin
               rsp_v    = 1'b1;
               rsp_err  = bus.mem_rsp_err;
               rsp_data = (owner_q == OWN_LSU && wen_q) ? '0 : bus.mem_rsp_data;
               last_d   = owner_q;
               state_d  = IDLE;
            end else if (TIMEOUT != 0 && cnt_q == LIMIT) begin
               rsp_v    = 1'b1;
               rsp_err  = 1'b1;
               last_d   = owner_q;
               state_d  = IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWN_IFU;
         last_q  <= OWN_LSU;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ifu_req_ready = ifu_ready;
   assign bus.lsu_req_ready = lsu_ready;
   assign bus.ifu_rsp_valid = rsp_v && (owner_q == OWN_IFU);
   assign bus.ifu_rsp_data  = (owner_q == OWN_IFU) ? rsp_data : '0;
   assign bus.ifu_rsp_err   = rsp_err && (owner_q == OWN_IFU);
   assign bus.lsu_rsp_valid = rsp_v && (owner_q == OWN_LSU);
   assign bus.lsu_rsp_data  = (owner_q == OWN_LSU) ? rsp_data : '0;
   assign bus.lsu_rsp_err   = rsp_err && (owner_q == OWN_LSU);
   assign bus.mem_req_valid = mem_valid;
   assign bus.mem_req_addr  = addr_q;
   assign bus.mem_req_wen   = wen_q;
   assign bus.mem_req_wdata = wdata_q;
   assign bus.mem_req_wmask = wmask_q;
   assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter, built with TIMEOUT=4.
module tb_mem_arbiter;

   logic clk;
   logic reset;
   logic busy;
   int   checks;
   int   failures;

   mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.ifu_req_valid = 1'b0;
      bus.ifu_req_addr  = '0;
      bus.lsu_req_valid = 1'b0;
      bus.lsu_req_addr  = '0;
      bus.lsu_req_wen   = 1'b0;
      bus.lsu_req_wdata = '0;
      bus.lsu_req_wmask = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      bus.mem_rsp_err   = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      bus.ifu_req_valid = 1'b1;
      bus.lsu_req_valid = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hFFFF_FFFF;
      bus.mem_rsp_err   = 1'b1;
      step(); step(); #1;
      checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid, busy, bus.ifu_rsp_valid,
           bus.lsu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rsp_err} !== 8'h00) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00000000", {bus.ifu_req_ready, bus.lsu_req_ready,
                  bus.mem_req_valid, busy, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rsp_err});
      end
      checks++;
      if ({bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wen, bus.mem_req_wmask} !== 69'h0) begin
         failures++;
         $display("FAIL reset_req_fields got=%h exp=0", {bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wen, bus.mem_req_wmask});
      end
      checks++;
      if ({bus.ifu_rsp_data, bus.lsu_rsp_data} !== 64'h0) begin
         failures++;
         $display("FAIL reset_rsp_data got=%h exp=0", {bus.ifu_rsp_data, bus.lsu_rsp_data});
      end
      clear_inputs();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_conflict();
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0004;
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_1000;
      bus.lsu_req_wen = 1'b1; bus.lsu_req_wdata = 32'hDEAD_BEEF; bus.lsu_req_wmask = 4'h3;
      bus.mem_req_ready = 1'b1;
      #1 checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
         failures++; $display("FAIL conf1_grant got=%b exp=10", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      step(); bus.ifu_req_valid = 1'b0;
      #1 checks++;
      if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask,
           bus.ifu_req_ready, bus.lsu_req_ready} !== {1'b1, 32'h8000_0004, 1'b0, 32'h0, 4'hF, 2'b00}) begin
         failures++; $display("FAIL conf1_ifu_issue got=%h_%h_%h_%h exp=1_80000004_0_f", bus.mem_req_valid,
                              bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wmask);
      end
      step(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0013;
      #1 checks++;
      if ({bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.ifu_rsp_err, bus.lsu_rsp_valid} !== {1'b1, 32'h13, 2'b00}) begin
         failures++; $display("FAIL conf1_ifu_rsp got=%b_%h_%b_%b exp=1_00000013_0_0", bus.ifu_rsp_valid,
                              bus.ifu_rsp_data, bus.ifu_rsp_err, bus.lsu_rsp_valid);
      end
      step(); bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
      #1 checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid} !== 3'b010) begin
         failures++; $display("FAIL conf1_lsu_grant got=%b exp=010", {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid});
      end
      step(); bus.lsu_req_valid = 1'b0;
      #1 checks++;
      if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask}
          !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3}) begin
         failures++; $display("FAIL conf1_lsu_issue got=%h_%h_%h_%h_%h exp=1_80001000_1_deadbeef_3", bus.mem_req_valid,
                              bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask);
      end
      step(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h5555_5555;
      #1 checks++;
      if ({bus.lsu_rsp_valid, bus.lsu_rsp_data, bus.lsu_rsp_err, bus.ifu_rsp_valid} !== {1'b1, 32'h0, 2'b00}) begin
         failures++; $display("FAIL conf1_store_rsp got=%b_%h_%b_%b exp=1_00000000_0_0", bus.lsu_rsp_valid,
                              bus.lsu_rsp_data, bus.lsu_rsp_err, bus.ifu_rsp_valid);
      end
      step(); bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0008;
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_2000;
      bus.lsu_req_wen = 1'b0; bus.lsu_req_wdata = '0; bus.lsu_req_wmask = 4'hF;
      #1 checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
         failures++; $display("FAIL conf2_grant got=%b exp=10", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      step(); bus.ifu_req_valid = 1'b0;
      step(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0093;
      #1 checks++;
      if ({bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.ifu_rsp_err} !== {1'b1, 32'h93, 1'b0}) begin
         failures++; $display("FAIL conf2_ifu_rsp got=%b_%h_%b exp=1_00000093_0", bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.ifu_rsp_err);
      end
      step(); bus.mem_rsp_valid = 1'b0;
      #1 checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
         failures++; $display("FAIL conf2_lsu_grant got=%b exp=01", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      step(); bus.lsu_req_valid = 1'b0;
      #1 checks++;
      if ({bus.mem_req_addr, bus.mem_req_wen} !== {32'h8000_2000, 1'b0}) begin
         failures++; $display("FAIL conf2_lsu_issue got=%h_%b exp=80002000_0", bus.mem_req_addr, bus.mem_req_wen);
      end
      step(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hA5A5_A5A5; bus.mem_rsp_err = 1'b1;
      #1 checks++;
      if ({bus.lsu_rsp_valid, bus.lsu_rsp_data, bus.lsu_rsp_err} !== {1'b1, 32'hA5A5_A5A5, 1'b1}) begin
         failures++; $display("FAIL conf2_load_err_rsp got=%b_%h_%b exp=1_a5a5a5a5_1", bus.lsu_rsp_valid, bus.lsu_rsp_data, bus.lsu_rsp_err);
      end
      step(); clear_inputs();
   endtask

   task automatic test_ifu_load();
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0000; bus.mem_req_ready = 1'b1;
      #1 checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.lsu_rsp_valid} !== 3'b100) begin
         failures++; $display("FAIL ifu_accept got=%b exp=100", {bus.ifu_req_ready, bus.lsu_req_ready, bus.lsu_rsp_valid});
      end
      step(); bus.ifu_req_valid = 1'b0;
      #1 checks++;
      if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wmask, bus.mem_req_wen, busy, bus.ifu_rsp_valid, bus.lsu_rsp_valid}
          !== {1'b1, 32'h8000_0000, 4'hF, 1'b0, 3'b100}) begin
         failures++; $display("FAIL ifu_issue got=%b_%h_%h_%b exp=1_80000000_f_0", bus.mem_req_valid,
                              bus.mem_req_addr, bus.mem_req_wmask, bus.mem_req_wen);
      end
      step(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0000_0413;
      #1 checks++;
      if ({bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.ifu_rsp_err, bus.lsu_rsp_valid, bus.mem_req_valid}
          !== {1'b1, 32'h413, 3'b000}) begin
         failures++; $display("FAIL ifu_rsp got=%b_%h_%b_%b exp=1_00000413_0_0", bus.ifu_rsp_valid,
                              bus.ifu_rsp_data, bus.ifu_rsp_err, bus.lsu_rsp_valid);
      end
      step(); bus.mem_rsp_valid = 1'b0;
      #1 checks++;
      if ({bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.lsu_rsp_valid, busy} !== 35'h0) begin
         failures++; $display("FAIL ifu_rsp_pulse got=%b_%h_%b_%b exp=0", bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.lsu_rsp_valid, busy);
      end
      step(); clear_inputs();
   endtask

   task automatic test_backpressure();
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_3000; bus.lsu_req_wen = 1'b0;
      bus.lsu_req_wdata = 32'h1111_2222; bus.lsu_req_wmask = 4'hC;
      #1 checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
         failures++; $display("FAIL bp_accept got=%b exp=01", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      step(); bus.lsu_req_valid = 1'b0; bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0010;
      for (int i = 0; i < 5; i++) begin
         bus.mem_rsp_valid = (i == 2);
         #1 checks++;
         if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask,
              bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid}
             !== {1'b1, 32'h8000_3000, 1'b0, 32'h1111_2222, 4'hC, 4'b0000}) begin
            failures++; $display("FAIL bp_hold_%0d got=%b_%h_%h_%h_%b%b%b%b exp=1_80003000_11112222_c_0000", i,
                                 bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask,
                                 bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid);
         end
         step();
      end
      bus.mem_rsp_valid = 1'b0; bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
      step(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hCAFE_F00D;
      #1 checks++;
      if ({bus.lsu_rsp_valid, bus.lsu_rsp_data, bus.lsu_rsp_err} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
         failures++; $display("FAIL bp_rsp got=%b_%h_%b exp=1_cafef00d_0", bus.lsu_rsp_valid, bus.lsu_rsp_data, bus.lsu_rsp_err);
      end
      step(); clear_inputs();
   endtask

   task automatic test_timeout();
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_4000; bus.lsu_req_wmask = 4'hF;
      bus.mem_req_ready = 1'b1;
      step(); bus.lsu_req_valid = 1'b0; bus.mem_rsp_data = 32'hDEAD_DEAD;
      step();
      for (int i = 0; i < 3; i++) begin
         #1 checks++;
         if ({bus.lsu_rsp_valid, bus.ifu_rsp_valid, bus.mem_req_valid, busy} !== 4'b0001) begin
            failures++; $display("FAIL to_wait_%0d got=%b exp=0001", i, {bus.lsu_rsp_valid, bus.ifu_rsp_valid, bus.mem_req_valid, busy});
         end
         step();
      end
      #1 checks++;
      if ({bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rsp_data, bus.ifu_rsp_valid} !== {2'b11, 32'h0, 1'b0}) begin
         failures++; $display("FAIL to_err_rsp got=%b_%b_%h_%b exp=1_1_00000000_0", bus.lsu_rsp_valid,
                              bus.lsu_rsp_err, bus.lsu_rsp_data, bus.ifu_rsp_valid);
      end
      step(); bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h0BAD_BAD0;
      #1 checks++;
      if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.lsu_rsp_err, busy} !== 4'b0000) begin
         failures++; $display("FAIL to_late_rsp got=%b exp=0000", {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.lsu_rsp_err, busy});
      end
      step(); clear_inputs();
   endtask

   task automatic test_rsp_on_limit();
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0020; bus.mem_req_ready = 1'b1;
      step(); bus.ifu_req_valid = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         #1 checks++;
         if (bus.ifu_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL lim_wait_%0d got=%b exp=0", i, bus.ifu_rsp_valid);
         end
         step();
      end
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1234_5678;
      #1 checks++;
      if ({bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.ifu_rsp_err} !== {1'b1, 32'h1234_5678, 1'b0}) begin
         failures++; $display("FAIL lim_rsp got=%b_%h_%b exp=1_12345678_0", bus.ifu_rsp_valid, bus.ifu_rsp_data, bus.ifu_rsp_err);
      end
      step(); clear_inputs();
   endtask

   task automatic test_reset_mid_wait();
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0030; bus.mem_req_ready = 1'b1;
      step(); bus.ifu_req_valid = 1'b0;
      step(); step();
      reset = 1'b1; bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h7777_7777;
      #1 checks++;
      if ({busy, bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid,
           bus.ifu_rsp_data, bus.mem_req_addr} !== 70'h0) begin
         failures++; $display("FAIL rst_mid_outputs got=%b_%h_%h exp=0", {busy, bus.ifu_req_ready, bus.lsu_req_ready,
                              bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.mem_req_valid}, bus.ifu_rsp_data, bus.mem_req_addr);
      end
      step(); reset = 1'b0; bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
      #1 checks++;
      if ({bus.ifu_rsp_valid, bus.lsu_rsp_valid, busy} !== 3'b000) begin
         failures++; $display("FAIL rst_stray_rsp got=%b exp=000", {bus.ifu_rsp_valid, bus.lsu_rsp_valid, busy});
      end
      step(); bus.mem_rsp_valid = 1'b0;
      bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0040;
      bus.lsu_req_valid = 1'b1; bus.lsu_req_addr = 32'h8000_5000;
      #1 checks++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
         failures++; $display("FAIL rst_first_conflict got=%b exp=10", {bus.ifu_req_ready, bus.lsu_req_ready});
      end
      step(); clear_inputs();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_conflict();
      test_ifu_load();
      test_backpressure();
      test_timeout();
      test_rsp_on_limit();
      test_reset_mid_wait();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
